// File: rtl/crossing_ctrl_pkg.sv
// Shared crossroads definitions: road status, signal aspect and controller
// state encodings, plus the phase-counter width helper. Imported by the
// controller, its interface and the road models.
package crossing_ctrl_pkg;

    typedef enum logic [1:0] {
        NO_CARS      = 2'd0,
        CAR_WAITING  = 2'd1,
        CARS_PASSING = 2'd2
    } traffic_status_t;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        GO   = 2'd1,
        SLOW = 2'd2
    } traffic_signal_t;

    typedef enum logic [1:0] {
        SLOW_TO_A,
        GO_A,
        SLOW_TO_B,
        GO_B
    } ctrl_state_t;

    localparam int WAIT_W = 8;

    // Phase counter must hold values up to max(slow_cycles, max_go) - 1.
    function automatic int cnt_width(input int slow_cycles, input int max_go);
        int m;
        m = (slow_cycles > max_go) ? slow_cycles : max_go;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/crossing_ctrl_if.sv
// Crossroads bus: road status in, signal aspects, wait counters and the
// collision flag out.
//   master : road side (drives status_a/status_b, observes the rest)
//   slave  : controller side (observes statuses, drives signals/waits/collision)
interface crossing_ctrl_if;
    import crossing_ctrl_pkg::*;

    logic [1:0]        status_a;
    logic [1:0]        status_b;
    logic [1:0]        signal_a;
    logic [1:0]        signal_b;
    logic [WAIT_W-1:0] wait_a;
    logic [WAIT_W-1:0] wait_b;
    logic              collision;

    modport master (
        output status_a, status_b,
        input  signal_a, signal_b, wait_a, wait_b, collision
    );

    modport slave (
        input  status_a, status_b,
        output signal_a, signal_b, wait_a, wait_b, collision
    );

endinterface

// File: rtl/crossing_ctrl_wait_counter.sv
// wait_counter: 8-bit saturating up-counter with clear and enable.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear; forces count to 0 in the same cycle and resets the
//                register at the next edge
//   en         : count one more cycle (saturates at 255)
//   count      : current count
module wait_counter
    import crossing_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    output logic [WAIT_W-1:0] count
);

    logic [WAIT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // A road holding go has waited zero cycles, including its first go cycle.
    assign count = clr ? '0 : cnt_q;

endmodule

// File: rtl/crossing_ctrl.sv
// crossing_ctrl: two-road crossing controller (Moore FSM).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : crossing_ctrl_if.slave
//                status_a/b in; signal_a/b, wait_a/b, collision out
// Handover always passes through SLOW_CYCLES of slow/slow. A road on go can
// be preempted by a waiting opposite road after MIN_GO cycles if it has no
// cars passing, or unconditionally after MAX_GO cycles.
module crossing_ctrl
    import crossing_ctrl_pkg::*;
#(
    parameter int SLOW_CYCLES = 2,
    parameter int MIN_GO      = 2,
    parameter int MAX_GO      = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    crossing_ctrl_if.slave bus
);

    localparam int CNT_W = cnt_width(SLOW_CYCLES, MAX_GO);
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_GO - 1);
    localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_GO - 1);

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sig_a, sig_b;
    logic             hand_to_b, hand_to_a;
    logic             collision_q;
    logic [WAIT_W-1:0] wait_a_cnt, wait_b_cnt;

    assign hand_to_b = (bus.status_b == CAR_WAITING) && (cnt_q >= MIN_LAST) &&
                       ((bus.status_a != CARS_PASSING) || (cnt_q == MAX_LAST));
    assign hand_to_a = (bus.status_a == CAR_WAITING) && (cnt_q >= MIN_LAST) &&
                       ((bus.status_b != CARS_PASSING) || (cnt_q == MAX_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOW_TO_A;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sig_a   = SLOW;
        sig_b   = SLOW;
        unique case (state_q)
            SLOW_TO_A: begin
                if (cnt_q == SLOW_LAST) begin
                    state_d = GO_A;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GO_A: begin
                sig_a = GO;
                sig_b = STOP;
                if (hand_to_b) begin
                    state_d = SLOW_TO_B;
                    cnt_d   = '0;
                end else if (cnt_q != MAX_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SLOW_TO_B: begin
                if (cnt_q == SLOW_LAST) begin
                    state_d = GO_B;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GO_B: begin
                sig_a = STOP;
                sig_b = GO;
                if (hand_to_a) begin
                    state_d = SLOW_TO_A;
                    cnt_d   = '0;
                end else if (cnt_q != MAX_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = SLOW_TO_A;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collision_q <= 1'b0;
        end else if ((bus.status_a == CARS_PASSING) && (bus.status_b == CARS_PASSING)) begin
            collision_q <= 1'b1;
        end
    end

    wait_counter u_wait_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q == GO_A),
        .en    (bus.status_a == CAR_WAITING),
        .count (wait_a_cnt)
    );

    wait_counter u_wait_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q == GO_B),
        .en    (bus.status_b == CAR_WAITING),
        .count (wait_b_cnt)
    );

    assign bus.signal_a  = sig_a;
    assign bus.signal_b  = sig_b;
    assign bus.wait_a    = wait_a_cnt;
    assign bus.wait_b    = wait_b_cnt;
    assign bus.collision = collision_q;

endmodule

// File: tb/tb_crossing_ctrl.sv
// Bench for crossing_ctrl: directed scenarios with literal expectations plus
// randomized road statuses compared every cycle against a behavioural model.
module tb_crossing_ctrl;
    import crossing_ctrl_pkg::*;

    localparam int M_SLOW = 2;
    localparam int M_MIN  = 2;
    localparam int M_MAX  = 8;

    logic clk = 1'b0;
    logic rst_n;
    bit   chk_en = 1'b0;
    int   nvec = 0;
    int   nmis = 0;

    always #5 clk = ~clk;

    crossing_ctrl_if bus1 ();
    crossing_ctrl_if bus2 ();

    crossing_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    crossing_ctrl #(.SLOW_CYCLES(3), .MIN_GO(3), .MAX_GO(400)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    // Model: owner = road that has or is about to get go (0=A, 1=B);
    // slow_left = remaining slow cycles; held = go cycles completed so far.
    typedef struct {
        int owner;
        int slow_left;
        int held;
        int wa;
        int wb;
        bit coll;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.owner = 0; r.slow_left = M_SLOW; r.held = 0;
        r.wa = 0; r.wb = 0; r.coll = 1'b0;
        return r;
    endfunction

    function automatic model_t model_step(input model_t c, input int sa, input int sb);
        model_t r;
        int own, oth;
        r = c;
        if (c.slow_left == 0 && c.owner == 0) r.wa = 0;
        else if (sa == 1) r.wa = (c.wa + 1 > 255) ? 255 : c.wa + 1;
        if (c.slow_left == 0 && c.owner == 1) r.wb = 0;
        else if (sb == 1) r.wb = (c.wb + 1 > 255) ? 255 : c.wb + 1;
        if (sa == 2 && sb == 2) r.coll = 1'b1;
        if (c.slow_left > 0) begin
            r.slow_left = c.slow_left - 1;
            r.held = 0;
        end else begin
            r.held = c.held + 1;
            own = (c.owner == 0) ? sa : sb;
            oth = (c.owner == 0) ? sb : sa;
            if (oth == 1 && r.held >= M_MIN && (own != 2 || r.held >= M_MAX)) begin
                r.owner = 1 - c.owner;
                r.slow_left = M_SLOW;
                r.held = 0;
            end
        end
        return r;
    endfunction

    function automatic int exp_sig(input model_t c, input int road);
        if (c.slow_left > 0) return int'(SLOW);
        return (c.owner == road) ? int'(GO) : int'(STOP);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_step(m, int'(bus1.status_a), int'(bus1.status_b));
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("signal_a", int'(bus1.signal_a), exp_sig(m, 0));
            chk("signal_b", int'(bus1.signal_b), exp_sig(m, 1));
            chk("wait_a", int'(bus1.wait_a), (m.slow_left == 0 && m.owner == 0) ? 0 : m.wa);
            chk("wait_b", int'(bus1.wait_b), (m.slow_left == 0 && m.owner == 1) ? 0 : m.wb);
            chk("collision", int'(bus1.collision), int'(m.coll));
            chk("one_go", int'(bus1.signal_a == GO && bus1.signal_b == GO), 0);
        end
    end

    task automatic chk_sigs(input string name, input int ea, input int eb);
        chk({name, "_a"}, int'(bus1.signal_a), ea);
        chk({name, "_b"}, int'(bus1.signal_b), eb);
    endtask

    function automatic logic [1:0] rnd_status();
        int r;
        r = $urandom_range(0, 9);
        if (r < 3) return 2'd0;
        if (r < 6) return 2'd1;
        if (r < 9) return 2'd2;
        return 2'd3;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n = 1'b0;
        bus1.status_a = 2'd0; bus1.status_b = 2'd0;
        bus2.status_a = 2'd0; bus2.status_b = 2'd0;
        #1;
        chk_sigs("reset_sig", int'(SLOW), int'(SLOW));
        chk("reset_wait_a", int'(bus1.wait_a), 0);
        chk("reset_wait_b", int'(bus1.wait_b), 0);
        chk("reset_coll", int'(bus1.collision), 0);

        // Release with no cars: two slow samples, then A holds go.
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; chk_en = 1'b1;
        chk_sigs("rel_slow0", int'(SLOW), int'(SLOW));
        @(negedge clk); chk_sigs("rel_slow1", int'(SLOW), int'(SLOW));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); chk_sigs("hold_go_a", int'(GO), int'(STOP));
        end

        // A empty, B waiting: immediate handover through two slow cycles.
        bus1.status_a = 2'd0; bus1.status_b = 2'd1;
        @(negedge clk); chk_sigs("ho_slow0", int'(SLOW), int'(SLOW));
        @(negedge clk); chk_sigs("ho_slow1", int'(SLOW), int'(SLOW));
        @(negedge clk); chk_sigs("ho_go_b", int'(STOP), int'(GO));

        // Back to A, then A passing with B waiting: preempted after 8 go cycles.
        bus1.status_a = 2'd1; bus1.status_b = 2'd0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (bus1.signal_a == GO) seen = 1'b1;
        end
        chk("reach_go_a", int'(seen), 1);
        bus1.status_a = 2'd2; bus1.status_b = 2'd1;
        for (int n = 0; n < 8; n++) begin
            chk_sigs("maxgo_hold", int'(GO), int'(STOP));
            @(negedge clk);
        end
        chk_sigs("maxgo_slow", int'(SLOW), int'(SLOW));

        // Collision: one cycle of both passing sets a sticky flag.
        bus1.status_a = 2'd2; bus1.status_b = 2'd2;
        @(negedge clk);
        bus1.status_a = 2'd0; bus1.status_b = 2'd0;
        chk("coll_set", int'(bus1.collision), 1);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk); chk("coll_sticky", int'(bus1.collision), 1);
        end
        #2 rst_n = 1'b0;
        #1 chk("coll_clr", int'(bus1.collision), 0);
        @(negedge clk); rst_n = 1'b1;

        // Reset in GO_B at cnt=3: slow/slow before the next edge, fresh start.
        bus1.status_a = 2'd0; bus1.status_b = 2'd1;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (bus1.signal_b == GO) seen = 1'b1;
        end
        chk("reach_go_b", int'(seen), 1);
        bus1.status_b = 2'd0;
        for (int n = 0; n < 3; n++) @(negedge clk);
        chk_sigs("pre_rst", int'(STOP), int'(GO));
        #2 rst_n = 1'b0;
        #1 chk_sigs("async_rst", int'(SLOW), int'(SLOW));
        chk("async_wait_b", int'(bus1.wait_b), 0);
        @(negedge clk); rst_n = 1'b1;
        chk_sigs("fresh_slow0", int'(SLOW), int'(SLOW));
        @(negedge clk); chk_sigs("fresh_slow1", int'(SLOW), int'(SLOW));
        @(negedge clk); chk_sigs("fresh_go_a", int'(GO), int'(STOP));

        // Second instance (SLOW 3, MIN 3, MAX 400): wait_b saturates at 255.
        @(negedge clk);
        bus2.status_a = 2'd2; bus2.status_b = 2'd1;
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        chk("w2_wait_b0", int'(bus2.wait_b), 0);
        chk("w2_sig_b0", int'(bus2.signal_b), int'(SLOW));
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            chk("w2_wait_b", int'(bus2.wait_b), (k > 255) ? 255 : k);
            chk("w2_sig_b", int'(bus2.signal_b), (k < 3) ? int'(SLOW) : int'(STOP));
        end
        bus2.status_a = 2'd0;
        for (int k = 301; k <= 304; k++) begin
            @(negedge clk);
            chk("w2_ho_wait_b", int'(bus2.wait_b), (k < 304) ? 255 : 0);
            chk("w2_ho_sig_b", int'(bus2.signal_b), (k < 304) ? int'(SLOW) : int'(GO));
        end
        bus2.status_a = 2'd0; bus2.status_b = 2'd0;

        // Randomized traffic with occasional asynchronous reset pulses.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 399) == 0) begin
                #3 rst_n = 1'b0;
                #1 chk_sigs("rnd_rst", int'(SLOW), int'(SLOW));
                @(negedge clk); rst_n = 1'b1;
            end
            bus1.status_a = rnd_status();
            bus1.status_b = rnd_status();
        end
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
